// File: rtl/easyaxi_slv_pkg.sv
// Shared types and constants for the EasyAXI read slave: R response codes and FSM states.
// Bus widths come from the AXI_ADDR_WIDTH / AXI_DATA_WIDTH macros (defaulted here if unset).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package easyaxi_slv_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Latency counter is wide enough for RD_LAT up to 255
    localparam int SLV_CNT_W = 8;

    typedef enum logic [1:0] {
        SLV_IDLE = 2'd0,
        SLV_WAIT = 2'd1,
        SLV_RESP = 2'd2
    } slv_state_e;

endpackage

// File: rtl/easyaxi_slv_fifo.sv
// In-order request queue for the read slave; head entry is visible on dout without a pop.
// Pushes while full and pops while empty are ignored.
module easyaxi_slv_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/easyaxi_slv.sv
// EasyAXI read slave: queues AR addresses, waits RD_LAT cycles, returns one R beat per request.
// Optional address decode error response is enabled with the EASYAXI_SLV_DECERR_EN macro.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module easyaxi_slv
    import easyaxi_slv_pkg::*;
#(
    parameter int                         FIFO_DEPTH   = 4,
    parameter int                         RD_LAT       = 2,
    parameter logic [`AXI_DATA_WIDTH-1:0] DATA_PATTERN = 'h5A5A5A5A,
    parameter logic [`AXI_ADDR_WIDTH-1:0] ADDR_LIMIT   = 'h100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    input  logic [`AXI_ADDR_WIDTH-1:0] axi_slv_araddr,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready,
    output logic [`AXI_DATA_WIDTH-1:0] axi_slv_rdata,
    output logic [1:0]                 axi_slv_rresp
);

    localparam int AW = `AXI_ADDR_WIDTH;
    localparam int DW = `AXI_DATA_WIDTH;
    localparam logic [SLV_CNT_W-1:0] LAT_LOAD = SLV_CNT_W'(RD_LAT);

    slv_state_e           state_reg, state_next;
    logic [SLV_CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]        addr_reg, addr_next;
    logic [DW-1:0]        rdata_reg, rdata_next;
    logic [1:0]           rresp_reg, rresp_next;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [AW-1:0]        fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic [AW-1:0]        resp_addr;
    logic [DW-1:0]        addr_ext;
    logic [DW-1:0]        resp_data;
    logic [1:0]           resp_code;

    assign axi_slv_arready = ~fifo_full;
    assign fifo_push       = axi_slv_arvalid & ~fifo_full;

    easyaxi_slv_fifo #(
        .WIDTH (AW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (axi_slv_araddr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // With zero latency the response is formed straight from the queue head
    assign resp_addr = (state_reg == SLV_IDLE) ? fifo_dout : addr_reg;

    for (genvar gi = 0; gi < DW; gi++) begin : g_addr_ext
        if (gi < AW) begin : g_bit
            assign addr_ext[gi] = resp_addr[gi];
        end else begin : g_zero
            assign addr_ext[gi] = 1'b0;
        end
    end

`ifdef EASYAXI_SLV_DECERR_EN
    logic decerr;
    assign decerr    = (resp_addr >= ADDR_LIMIT);
    assign resp_code = decerr ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign resp_data = decerr ? '0 : (addr_ext ^ DATA_PATTERN);
`else
    assign resp_code = AXI_RESP_OKAY;
    assign resp_data = addr_ext ^ DATA_PATTERN;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SLV_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rdata_reg <= '0;
            rresp_reg <= AXI_RESP_OKAY;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            rdata_reg <= rdata_next;
            rresp_reg <= rresp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        rdata_next = rdata_reg;
        rresp_next = rresp_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            SLV_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    addr_next = fifo_dout;
                    if (RD_LAT == 0) begin
                        state_next = SLV_RESP;
                        rdata_next = resp_data;
                        rresp_next = resp_code;
                    end else begin
                        cnt_next   = LAT_LOAD;
                        state_next = SLV_WAIT;
                    end
                end
            end
            SLV_WAIT: begin
                cnt_next = cnt_reg - SLV_CNT_W'(1);
                if (cnt_reg == SLV_CNT_W'(1)) begin
                    state_next = SLV_RESP;
                    rdata_next = resp_data;
                    rresp_next = resp_code;
                end
            end
            SLV_RESP: begin
                if (axi_slv_rready) begin
                    state_next = SLV_IDLE;
                end
            end
            default: state_next = SLV_IDLE;
        endcase
    end

    assign axi_slv_rvalid = (state_reg == SLV_RESP);
    assign axi_slv_rdata  = rdata_reg;
    assign axi_slv_rresp  = rresp_reg;

endmodule

// File: tb/tb_easyaxi_slv.sv
// Self-checking bench for easyaxi_slv: directed vector table, multi-cycle corner sequences
// and a randomized run checked against a queue-based reference model.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_easyaxi_slv;

    localparam int AW    = `AXI_ADDR_WIDTH;
    localparam int DW    = `AXI_DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam logic [DW-1:0] PAT   = 'h5A5A5A5A;
    localparam logic [AW-1:0] LIMIT = 'h100;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [AW-1:0] araddr  = '0;
    logic          rvalid;
    logic          rready  = 1'b0;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    easyaxi_slv #(
        .FIFO_DEPTH   (DEPTH),
        .RD_LAT       (LAT),
        .DATA_PATTERN (PAT),
        .ADDR_LIMIT   (LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_araddr  (araddr),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic          ar_fire;
    logic          r_fire;
    logic [DW-1:0] r_data_s;
    logic [1:0]    r_resp_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs set; records handshakes at the next rising edge
    task automatic step();
        ar_fire  = arvalid & arready;
        r_fire   = rvalid & rready;
        r_data_s = rdata;
        r_resp_s = rresp;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reference: address zero-extended/truncated to the data width, XORed with the pattern
    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        logic [DW-1:0] z = '0;
        for (int b = 0; b < DW && b < AW; b++) z[b] = a[b];
`ifdef EASYAXI_SLV_DECERR_EN
        if (a >= LIMIT) return '0;
`endif
        return z ^ PAT;
    endfunction

    function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
`ifdef EASYAXI_SLV_DECERR_EN
        if (a >= LIMIT) return 2'b11;
`endif
        return 2'b00;
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int extra;
        int k;
        int acc;
        int beats;
        int first_beat_cyc;
        int ar5_cyc;
        int last_cyc;
        int issued;
        int got;
        logic [AW-1:0] next_addr;
        logic [AW-1:0] ord_addr[3];
        logic [DW-1:0] ord_data[3];
        logic [DW+1:0] exp_q[$];
        logic [DW+1:0] e;
        logic          stall_now;
        logic [DW-1:0] data_now;

        vecs[0] = '{addr: 32'h0000_0000, data: 32'h5A5A_5A5A, resp: 2'b00};
        vecs[1] = '{addr: 32'h0000_0003, data: 32'h5A5A_5A59, resp: 2'b00};
        vecs[2] = '{addr: 32'h0000_00FF, data: 32'h5A5A_5AA5, resp: 2'b00};
`ifdef EASYAXI_SLV_DECERR_EN
        vecs[3] = '{addr: 32'h0000_0100, data: 32'h0000_0000, resp: 2'b11};
        vecs[4] = '{addr: 32'h0000_1234, data: 32'h0000_0000, resp: 2'b11};
        vecs[5] = '{addr: 32'hFFFF_FFFF, data: 32'h0000_0000, resp: 2'b11};
`else
        vecs[3] = '{addr: 32'h0000_0100, data: 32'h5A5A_5B5A, resp: 2'b00};
        vecs[4] = '{addr: 32'h0000_1234, data: 32'h5A5A_486E, resp: 2'b00};
        vecs[5] = '{addr: 32'hFFFF_FFFF, data: 32'hA5A5_A5A5, resp: 2'b00};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rresp", 64'(rresp), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single reads: latency, data, response, exactly one beat
        foreach (vecs[i]) begin
            araddr  = vecs[i].addr;
            arvalid = 1'b1;
            rready  = 1'b0;
            step();
            check("vec_ar_accept", 64'(ar_fire), 64'd1);
            arvalid = 1'b0;
            lat = 0;
            while (!rvalid && lat < 20) begin
                step();
                lat++;
            end
            check("vec_latency", 64'(lat), 64'(LAT + 1));
            check("vec_rdata", 64'(rdata), 64'(vecs[i].data));
            check("vec_rresp", 64'(rresp), 64'(vecs[i].resp));
            rready = 1'b1;
            step();
            check("vec_r_fire", 64'(r_fire), 64'd1);
            rready = 1'b0;
            extra = 0;
            repeat (6) begin
                if (rvalid) extra++;
                step();
            end
            check("vec_one_beat", 64'(extra), 64'd0);
            $display("[TB] vec %0d addr=0x%0h rdata=0x%0h rresp=%0d lat=%0d",
                     i, vecs[i].addr, r_data_s, r_resp_s, lat);
        end

        // Fill with rready low: FIFO_DEPTH queued plus one held in the FSM
        rready = 1'b0;
        acc = 0;
        repeat (8) begin
            arvalid = 1'b1;
            araddr  = AW'(acc);
            step();
            if (ar_fire) acc++;
        end
        check("fill_accepted", 64'(acc), 64'(DEPTH + 1));
        check("fill_arready", 64'(arready), 64'd0);
        repeat (10) begin
            check("fill_hold", {31'd0, rvalid, rdata}, {31'd0, 1'b1, PAT});
            step();
            if (ar_fire) acc++;
        end
        check("fill_still_blocked", 64'(acc), 64'(DEPTH + 1));
        $display("[TB] fill accepted=%0d rdata held=0x%0h", acc, rdata);

        // Release: addr 5 enters two edges after the first R beat (pop, then arready)
        rready = 1'b1;
        beats = 0;
        first_beat_cyc = -1;
        ar5_cyc = -1;
        for (int c = 0; c < 60 && beats < 6; c++) begin
            arvalid = (acc < 6);
            araddr  = AW'(acc);
            step();
            if (ar_fire) begin
                if (acc == 5) ar5_cyc = cyc;
                acc++;
            end
            if (r_fire) begin
                check("drain_rdata", 64'(r_data_s), 64'(PAT ^ DW'(beats)));
                if (beats == 0) first_beat_cyc = cyc;
                $display("[TB] drain beat %0d rdata=0x%0h", beats, r_data_s);
                beats++;
            end
        end
        arvalid = 1'b0;
        check("drain_beats", 64'(beats), 64'd6);
        check("drain_ar5_timing", 64'(ar5_cyc - first_beat_cyc), 64'd2);

        // Ordering with rready high: responses in order, RD_LAT+2 cycles apart
        ord_addr[0] = 'h3; ord_addr[1] = 'h1; ord_addr[2] = 'h2;
        ord_data[0] = 'h5A5A5A59; ord_data[1] = 'h5A5A5A5B; ord_data[2] = 'h5A5A5A58;
        rready = 1'b1;
        k = 0;
        beats = 0;
        last_cyc = 0;
        for (int c = 0; c < 40 && beats < 3; c++) begin
            arvalid = (k < 3);
            araddr  = ord_addr[k < 3 ? k : 2];
            step();
            if (ar_fire) k++;
            if (r_fire) begin
                check("order_rdata", 64'(r_data_s), 64'(ord_data[beats]));
                if (beats > 0) check("order_gap", 64'(cyc - last_cyc), 64'(LAT + 2));
                $display("[TB] order beat %0d rdata=0x%0h cycle=%0d", beats, r_data_s, cyc);
                last_cyc = cyc;
                beats++;
            end
        end
        arvalid = 1'b0;
        check("order_beats", 64'(beats), 64'd3);

        // Reset mid-operation: one beat pending, two queued
        rready = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && (k < 3 || !rvalid); c++) begin
            arvalid = (k < 3);
            araddr  = AW'(32'h10 + k);
            step();
            if (ar_fire) k++;
        end
        arvalid = 1'b0;
        check("rstmid_pending", 64'(rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_rvalid", 64'(rvalid), 64'd0);
        check("rstmid_arready", 64'(arready), 64'd1);
        check("rstmid_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        beats = 0;
        repeat (20) begin
            step();
            if (r_fire) beats++;
        end
        check("rstmid_no_stale", 64'(beats), 64'd0);
        $display("[TB] reset mid-op: stale beats=%0d", beats);

        // Randomized traffic against the queue model
        next_addr = AW'(32'h40);
        issued = 0;
        got = 0;
        arvalid = 1'b0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            if (!arvalid && issued < 1000 && $urandom_range(0, 3) != 0) begin
                arvalid = 1'b1;
                araddr  = next_addr;
            end
            rready    = ($urandom_range(0, 2) != 0);
            stall_now = rvalid & ~rready;
            data_now  = rdata;
            step();
            if (ar_fire) begin
                exp_q.push_back({model_resp(araddr), model_data(araddr)});
                next_addr = next_addr + AW'(1);
                issued++;
                arvalid = 1'b0;
            end
            if (r_fire) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_beat", 64'({r_resp_s, r_data_s}), 64'(e));
                    $display("[TB] rnd beat %0d rdata=0x%0h rresp=%0d", got, r_data_s, r_resp_s);
                end
                got++;
            end
            if (stall_now) begin
                check("rnd_hold", {31'd0, rvalid, rdata}, {31'd0, 1'b1, data_now});
            end
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        check("rnd_beats", 64'(got), 64'd1000);
        check("rnd_leftover", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
